// File: rtl/dnn_zf_pkg.sv
// Shared definitions for the zero-skip brick path: default brick geometry and
// the {offset, value} pair layout used by the encoder and compressor-side consumers.
package dnn_zf_pkg;

    localparam int unsigned NEURON_W   = 16;
    localparam int unsigned BRICK_SIZE = 16;
    localparam int unsigned OFF_W      = $clog2(BRICK_SIZE);

    typedef struct packed {
        logic [OFF_W-1:0]    offset;
        logic [NEURON_W-1:0] value;
    } zf_pair_t;

    function automatic zf_pair_t zf_pack(input logic [OFF_W-1:0] offset,
                                         input logic [NEURON_W-1:0] value);
        zf_pair_t p;
        p.offset = offset;
        p.value  = value;
        return p;
    endfunction

endpackage

// File: rtl/zf_out_reg.sv
// Single-entry valid/ready output register holding one SRAM write (addr + data).
// Can accept a new entry in the same cycle the held one drains.
module zf_out_reg #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        in_ready = ~valid_q | out_ready;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                addr_d = in_addr;
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;

endmodule

// File: rtl/zfnaf_brick_encoder.sv
// Groups a dense neuron stream into bricks, emits one packed {offset, value}
// SRAM write per non-zero value and reports each closed brick's non-zero count.
module zfnaf_brick_encoder #(
    parameter  int unsigned N          = dnn_zf_pkg::NEURON_W,
    parameter  int unsigned ADDR_SIZE  = 16,
    parameter  int unsigned BRICK_SIZE = dnn_zf_pkg::BRICK_SIZE,
    localparam int unsigned OFF_W      = $clog2(BRICK_SIZE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [ADDR_SIZE-1:0] i_base_addr,
    input  logic                 i_valid,
    input  logic [N-1:0]         i_data,
    output logic                 o_ready,
    output logic                 o_wr_valid,
    output logic [ADDR_SIZE-1:0] o_wr_addr,
    output logic [N+OFF_W-1:0]   o_wr_data,
    input  logic                 i_wr_ready,
    output logic                 o_brick_done,
    output logic [OFF_W:0]       o_brick_nnz
);

    logic [OFF_W-1:0]     elem_q, elem_d, elem_cur;
    logic [OFF_W:0]       slot_q, slot_d, slot_cur;
    logic [ADDR_SIZE-1:0] brick_q, brick_d, brick_cur;
    logic                 done_q, done_d;
    logic [OFF_W:0]       nnz_q, nnz_d;

    logic                 acc;
    logic                 nz;
    logic                 push;
    logic [ADDR_SIZE-1:0] push_addr;
    logic [N+OFF_W-1:0]   push_data;

    always_comb begin
        // i_start takes effect before the same-cycle input, so that value lands at elem 0 of brick 0
        elem_cur  = i_start ? '0 : elem_q;
        slot_cur  = i_start ? '0 : slot_q;
        brick_cur = i_start ? '0 : brick_q;

        acc       = i_valid & o_ready;
        nz        = (i_data != '0);
        push      = acc & nz;
        push_addr = i_base_addr + (brick_cur << OFF_W) + ADDR_SIZE'(slot_cur);
        push_data = {elem_cur, i_data};

        elem_d  = elem_cur;
        slot_d  = slot_cur;
        brick_d = brick_cur;
        done_d  = 1'b0;
        nnz_d   = '0;

        if (acc) begin
            if (elem_cur == OFF_W'(BRICK_SIZE - 1)) begin
                elem_d  = '0;
                slot_d  = '0;
                brick_d = brick_cur + 1'b1;
                done_d  = 1'b1;
                nnz_d   = slot_cur + (OFF_W+1)'(nz);
            end else begin
                elem_d  = elem_cur + 1'b1;
                slot_d  = slot_cur + (OFF_W+1)'(nz);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            elem_q  <= '0;
            slot_q  <= '0;
            brick_q <= '0;
            done_q  <= 1'b0;
            nnz_q   <= '0;
        end else begin
            elem_q  <= elem_d;
            slot_q  <= slot_d;
            brick_q <= brick_d;
            done_q  <= done_d;
            nnz_q   <= nnz_d;
        end
    end

    zf_out_reg #(
        .AW (ADDR_SIZE),
        .DW (N + OFF_W)
    ) u_out_reg (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_valid  (push),
        .in_addr   (push_addr),
        .in_data   (push_data),
        .in_ready  (o_ready),
        .out_valid (o_wr_valid),
        .out_addr  (o_wr_addr),
        .out_data  (o_wr_data),
        .out_ready (i_wr_ready)
    );

    assign o_brick_done = done_q;
    assign o_brick_nnz  = nnz_q;

endmodule
